flow_bus_arbiter: RTL and testbench
===================================

Name: flow_bus_arbiter

Overview:
- Merges NUM_PORTS upstream flow buses (data/valid/ready, plus an optional last flag) onto one downstream flow bus using round-robin arbitration.
- When packet mode is enabled, the grant is held from the first beat of a packet until its last beat.
- The output is a single register stage, so it can drive a flow_bus_register chain directly.
- Sits in front of shared stream sinks such as a host FIFO, a memory writer or a shared compute core.

Parameters:
- NUM_PORTS, 4, number of requesting upstream buses; legal values are 2 or more.
- DATA_WIDTH, 16, width of each data bus.
- USE_LAST, 1, 1 = the grant is locked per packet (released on up_last); 0 = arbitration happens on every beat and up_last/down_last are ignored and driven 0.
- PORT_BITS, clog2(NUM_PORTS), width of down_port. Derived; must not be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- up_valid  in  NUM_PORTS  per-port valid; bit i belongs to port i
- up_data  in  NUM_PORTS*DATA_WIDTH  packed data; port i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- up_last  in  NUM_PORTS  per-port end-of-packet flag
- up_ready  out  NUM_PORTS  per-port ready; at most one bit is high at a time
- down_valid  out  1  output register holds a beat
- down_data  out  DATA_WIDTH  registered data
- down_last  out  1  registered end-of-packet flag
- down_port  out  PORT_BITS  index of the source port of the beat currently on the output
- down_ready  in  1  downstream accepts the beat
- locked  out  1  a packet is in progress (registered)

Behaviour:
- Reset (async, rst=1):
  - down_valid, down_data, down_last, down_port, locked all go to 0.
  - rr_ptr goes to 0 and lock_idx goes to 0.
  - Any in-flight beat is discarded. Ports are not flushed.
- Definitions:
  - can_load = ~down_valid | down_ready.
  - sel is the port chosen this cycle.
- Selection:
  - If locked=1, sel = lock_idx.
  - Otherwise sel is the first i with up_valid[i]=1, scanning from rr_ptr upward and wrapping NUM_PORTS-1 -> 0.
- Ready:
  - up_ready[i] = can_load & (i==sel) & (locked | up_valid[i]).
  - This is combinational; up_ready may depend on up_valid.
  - When locked=1 the locked port sees ready whenever can_load is true, even if it is not valid.
- Transfer condition: up_valid[sel] & up_ready[sel]. On a transfer, in the next cycle:
  - down_data <= that port's data, down_last <= up_last[sel] & USE_LAST, down_port <= sel, down_valid <= 1.
- Output drain: down_valid <= 0 when down_ready=1 and no transfer occurs that cycle.
- Stability: while down_valid=1 and down_ready=0, down_data, down_last and down_port are held and all up_ready bits are 0.
- Throughput: one beat per clock when down_ready is held high. Latency is 1 cycle from the upstream handshake to down_valid.
- State machine (USE_LAST=1), states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED on a transfer with up_last[sel]=0; lock_idx <= sel.
  - UNLOCKED stays UNLOCKED on a transfer with up_last=1 (single-beat packet); rr_ptr <= sel+1 mod NUM_PORTS.
  - LOCKED -> UNLOCKED on a transfer with up_last[lock_idx]=1; rr_ptr <= lock_idx+1 mod NUM_PORTS.
  - LOCKED otherwise holds, regardless of other ports' valids. There is no timeout: a stalled locked port stalls the bus.
- USE_LAST=0: locked is tied to 0, and rr_ptr <= sel+1 mod NUM_PORTS after every transfer.
- Wrap-around: when sel+1 equals NUM_PORTS, rr_ptr wraps to 0. This must be correct for non-power-of-two NUM_PORTS.
- No valid on any port: no transfer occurs; rr_ptr and the lock state are unchanged.
- Simultaneous drain and load: the output register is overwritten in the same cycle. There is no bubble, no duplicate and no loss.

Decomposition:
- Shared include (`ifndef guarded) holds:
  - a clog2 function;
  - the state encodings ARB_UNLOCKED=1'b0 and ARB_LOCKED=1'b1.
- One natural sub-module: rr_priority_select, a combinational round-robin finder.
  - Inputs: request vector and pointer.
  - Outputs: found flag and index.
  - It is reusable by other arbiters.
- Packing, lock FSM and output register stay in the top module.

Test Plan:
- Reset: assert rst mid-stream with down_valid=1 -> down_valid, down_port and locked read 0 immediately (no clock edge needed); after release with all up_valid=0, up_ready=0.
- Round-robin: NUM_PORTS=4, USE_LAST=0, all ports valid continuously, down_ready=1 -> down_port sequence 0,1,2,3,0,1; one beat per cycle; each port's data matches its stream order.
- Packet lock: port 2 sends 3 beats (last on beat 3) while port 0 is always valid -> down_port 2,2,2 then 0; locked is 1 after beat 1 and 0 after beat 3; down_last=1 only on beat 3.
- Backpressure: down_ready=0 for 5 cycles with down_valid=1 -> down_data, down_port and down_last stay stable and up_ready=0; after release, the beat sequence resumes with no duplicate or missing beat (scoreboard per port).
- Wrap and sparse requests: rr_ptr=3 with only port 1 valid -> sel=1 and the next rr_ptr is 2; NUM_PORTS=3 with all valid -> down_port 0,1,2,0.
- Locked idle: port 1 locked and deasserts valid for 4 cycles while port 3 is valid -> no transfer from port 3 until port 1 sends its last beat.

Source files
------------

// File: rtl/flow_bus_arbiter_pkg.sv
// Shared types and helpers for the flow bus arbiter.
// Holds the lock FSM encoding and a constant-foldable clog2.
package flow_bus_arbiter_pkg;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

    // Width needed to index n items; never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned bits;
        int unsigned span;
        bits = 0;
        span = 1;
        while (span < n) begin
            span = span << 1;
            bits = bits + 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/flow_bus_arbiter_select.sv
// Combinational round-robin finder: first set request at or after ptr_i, wrapping.
// Reusable by any arbiter that keeps its own pointer.
module rr_priority_select #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_c,
    output logic [IW-1:0] idx_c
);

    always_comb begin
        int unsigned pos;
        found_c = 1'b0;
        idx_c   = '0;
        pos     = 0;
        for (int k = 0; k < int'(N); k++) begin
            pos = int'(ptr_i) + unsigned'(k);
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found_c && req_i[IW'(pos)]) begin
                found_c = 1'b1;
                idx_c   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/flow_bus_arbiter.sv
// Round-robin merge of NUM_PORTS flow buses onto one registered downstream bus,
// optionally holding the grant for a whole packet (up_last terminated).
module flow_bus_arbiter
    import flow_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned USE_LAST   = 1,
    parameter int unsigned PORT_BITS  = clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            up_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] up_data,
    input  logic [NUM_PORTS-1:0]            up_last,
    output logic [NUM_PORTS-1:0]            up_ready,
    output logic                            down_valid,
    output logic [DATA_WIDTH-1:0]           down_data,
    output logic                            down_last,
    output logic [PORT_BITS-1:0]            down_port,
    input  logic                            down_ready,
    output logic                            locked
);

    arb_state_e              state_q, state_d;
    logic [PORT_BITS-1:0]    lock_idx_q, lock_idx_d;
    logic [PORT_BITS-1:0]    rr_ptr_q, rr_ptr_d;
    logic                    down_valid_q, down_valid_d;
    logic [DATA_WIDTH-1:0]   down_data_q, down_data_d;
    logic                    down_last_q, down_last_d;
    logic [PORT_BITS-1:0]    down_port_q, down_port_d;

    logic                    can_load_c;
    logic                    rr_found_c;
    logic [PORT_BITS-1:0]    rr_idx_c;
    logic [PORT_BITS-1:0]    sel_c;
    logic [PORT_BITS-1:0]    next_ptr_c;
    logic                    sel_last_c;
    logic                    xfer_c;

    rr_priority_select #(
        .N  (NUM_PORTS),
        .IW (PORT_BITS)
    ) u_select (
        .req_i   (up_valid),
        .ptr_i   (rr_ptr_q),
        .found_c (rr_found_c),
        .idx_c   (rr_idx_c)
    );

    // Grant, handshake and lock FSM next-state.
    always_comb begin
        state_d      = state_q;
        lock_idx_d   = lock_idx_q;
        rr_ptr_d     = rr_ptr_q;
        down_valid_d = down_valid_q;
        down_data_d  = down_data_q;
        down_last_d  = down_last_q;
        down_port_d  = down_port_q;
        up_ready     = '0;

        can_load_c = ~down_valid_q | down_ready;
        sel_c      = (state_q == ARB_LOCKED) ? lock_idx_q : rr_idx_c;
        if (can_load_c && ((state_q == ARB_LOCKED) || rr_found_c)) begin
            up_ready[sel_c] = 1'b1;
        end
        xfer_c     = up_valid[sel_c] & up_ready[sel_c];
        sel_last_c = (USE_LAST != 0) && up_last[sel_c];
        // Explicit compare keeps the wrap right for non-power-of-two port counts.
        next_ptr_c = (sel_c == PORT_BITS'(NUM_PORTS - 1)) ? '0 : sel_c + PORT_BITS'(1);

        if (xfer_c) begin
            down_valid_d = 1'b1;
            down_data_d  = up_data[32'(sel_c) * DATA_WIDTH +: DATA_WIDTH];
            down_last_d  = sel_last_c;
            down_port_d  = sel_c;
            if (USE_LAST == 0) begin
                rr_ptr_d = next_ptr_c;
            end else begin
                unique case (state_q)
                    ARB_UNLOCKED: begin
                        if (sel_last_c) begin
                            rr_ptr_d = next_ptr_c;
                        end else begin
                            state_d    = ARB_LOCKED;
                            lock_idx_d = sel_c;
                        end
                    end
                    ARB_LOCKED: begin
                        if (sel_last_c) begin
                            state_d  = ARB_UNLOCKED;
                            rr_ptr_d = next_ptr_c;
                        end
                    end
                endcase
            end
        end else if (down_ready) begin
            down_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_UNLOCKED;
            lock_idx_q   <= '0;
            rr_ptr_q     <= '0;
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            down_last_q  <= 1'b0;
            down_port_q  <= '0;
        end else begin
            state_q      <= state_d;
            lock_idx_q   <= lock_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
            down_last_q  <= down_last_d;
            down_port_q  <= down_port_d;
        end
    end

    assign down_valid = down_valid_q;
    assign down_data  = down_data_q;
    assign down_last  = down_last_q;
    assign down_port  = down_port_q;
    assign locked     = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_flow_bus_arbiter.sv
// Self-checking bench for flow_bus_arbiter: packet-mode instance checked against a
// behavioural model and per-port scoreboard, plus per-beat instances with 4 and 3 ports.
module tb_flow_bus_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned N3 = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned PB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Instance A: 4 ports, packet mode
    logic [N-1:0]    a_valid, a_last, a_ready;
    logic [N*DW-1:0] a_data;
    logic            a_dvalid, a_dlast, a_dready, a_locked;
    logic [DW-1:0]   a_ddata;
    logic [PB-1:0]   a_dport;

    // Instance B: 4 ports, per-beat arbitration
    logic [N-1:0]    b_valid, b_last, b_ready;
    logic [N*DW-1:0] b_data;
    logic            b_dvalid, b_dlast, b_dready, b_locked;
    logic [DW-1:0]   b_ddata;
    logic [PB-1:0]   b_dport;

    // Instance C: 3 ports, per-beat arbitration
    logic [N3-1:0]    c_valid, c_last, c_ready;
    logic [N3*DW-1:0] c_data;
    logic             c_dvalid, c_dlast, c_dready, c_locked;
    logic [DW-1:0]    c_ddata;
    logic [PB-1:0]    c_dport;

    flow_bus_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .USE_LAST(1)) u_dut_a (
        .clk(clk), .rst(rst), .up_valid(a_valid), .up_data(a_data), .up_last(a_last),
        .up_ready(a_ready), .down_valid(a_dvalid), .down_data(a_ddata), .down_last(a_dlast),
        .down_port(a_dport), .down_ready(a_dready), .locked(a_locked));

    flow_bus_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .USE_LAST(0)) u_dut_b (
        .clk(clk), .rst(rst), .up_valid(b_valid), .up_data(b_data), .up_last(b_last),
        .up_ready(b_ready), .down_valid(b_dvalid), .down_data(b_ddata), .down_last(b_dlast),
        .down_port(b_dport), .down_ready(b_dready), .locked(b_locked));

    flow_bus_arbiter #(.NUM_PORTS(N3), .DATA_WIDTH(DW), .USE_LAST(0)) u_dut_c (
        .clk(clk), .rst(rst), .up_valid(c_valid), .up_data(c_data), .up_last(c_last),
        .up_ready(c_ready), .down_valid(c_dvalid), .down_data(c_ddata), .down_last(c_dlast),
        .down_port(c_dport), .down_ready(c_dready), .locked(c_locked));

    // Reference model state for instance A: pointer, lock and the output register contents.
    int          m_ptr = 0;
    int          m_lock_idx = 0;
    bit          m_locked = 0;
    bit          m_dv = 0;
    bit          m_dl = 0;
    int          m_dp = 0;
    logic [15:0] m_dd = '0;
    int          src_seq[N];
    int          sink_seq[N];

    // One clock of instance A: check ready pre-edge, step model, check outputs post-edge.
    task automatic cycle_a();
        int          sel;
        int          p;
        int          q;
        bit          found;
        bit          can_load;
        bit          xfer;
        logic [N-1:0] exp_ready;
        for (int i = 0; i < int'(N); i++) a_data[i*DW +: DW] = {4'(i), 12'(src_seq[i])};
        #1;
        can_load = !m_dv || a_dready;
        found    = m_locked;
        sel      = m_lock_idx;
        if (!m_locked) begin
            for (int k = 0; k < int'(N); k++) begin
                q = (m_ptr + k) % N;
                if (!found && a_valid[q]) begin
                    found = 1;
                    sel   = q;
                end
            end
        end
        exp_ready = '0;
        if (can_load && found) exp_ready[sel] = 1'b1;
        xfer = exp_ready[sel] && a_valid[sel];
        compared++;
        if (a_ready !== exp_ready) begin
            mismatched++;
            $display("FAIL a_up_ready t=%0t: got %b expected %b", $time, a_ready, exp_ready);
        end
        if (a_dvalid === 1'b1 && a_dready) begin
            p = int'(a_ddata[15:12]);
            compared++;
            if (p >= int'(N)) begin
                mismatched++;
                $display("FAIL a_sink_port t=%0t: got %0d expected below %0d", $time, p, N);
            end else begin
                if (a_ddata[11:0] !== 12'(sink_seq[p])) begin
                    mismatched++;
                    $display("FAIL a_sink_seq port %0d t=%0t: got %0d expected %0d",
                             p, $time, a_ddata[11:0], sink_seq[p]);
                end
                sink_seq[p]++;
            end
        end
        @(posedge clk);
        if (xfer) begin
            m_dv = 1;
            m_dd = {4'(sel), 12'(src_seq[sel])};
            m_dl = a_last[sel];
            m_dp = sel;
            src_seq[sel]++;
            if (!m_locked) begin
                if (a_last[sel]) m_ptr = (sel + 1) % N;
                else begin
                    m_locked   = 1;
                    m_lock_idx = sel;
                end
            end else if (a_last[sel]) begin
                m_locked = 0;
                m_ptr    = (sel + 1) % N;
            end
        end else if (a_dready) begin
            m_dv = 0;
        end
        #1;
        compared++;
        if (a_dvalid !== m_dv || a_locked !== m_locked) begin
            mismatched++;
            $display("FAIL a_valid_locked t=%0t: got %b/%b expected %b/%b",
                     $time, a_dvalid, a_locked, m_dv, m_locked);
        end
        if (m_dv) begin
            compared++;
            if (a_ddata !== m_dd || a_dport !== PB'(m_dp) || a_dlast !== m_dl) begin
                mismatched++;
                $display("FAIL a_beat t=%0t: got data %h port %0d last %b expected %h %0d %b",
                         $time, a_ddata, a_dport, a_dlast, m_dd, m_dp, m_dl);
            end
        end
    endtask

    task automatic test_reset();
        a_valid = '0; a_last = '0; a_dready = 1'b1;
        b_valid = '0; b_last = '0; b_dready = 1'b1; b_data = '0;
        c_valid = '0; c_last = '0; c_dready = 1'b1; c_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            src_seq[i]  = 0;
            sink_seq[i] = 0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (a_dvalid !== 1'b0 || a_ddata !== '0 || a_dlast !== 1'b0 || a_dport !== '0 || a_locked !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_values: got v%b d%h l%b p%0d k%b expected all zero",
                     a_dvalid, a_ddata, a_dlast, a_dport, a_locked);
        end
        #2 rst = 1'b0;
        // Leave a locked, stalled beat in the output register, then reset mid-cycle.
        a_valid = 4'b0100; a_last = '0; a_dready = 1'b0;
        cycle_a();
        a_valid = '0;
        cycle_a();
        #2 rst = 1'b1;
        #1;
        compared++;
        if (a_dvalid !== 1'b0 || a_dport !== '0 || a_locked !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: got v%b p%0d k%b expected 0 0 0", a_dvalid, a_dport, a_locked);
        end
        m_ptr = 0; m_lock_idx = 0; m_locked = 0; m_dv = 0; m_dl = 0; m_dp = 0; m_dd = '0;
        for (int i = 0; i < int'(N); i++) sink_seq[i] = src_seq[i];
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        a_dready = 1'b1;
        #1;
        compared++;
        if (a_ready !== 4'b0000) begin
            mismatched++;
            $display("FAIL ready_after_reset: got %b expected 0000", a_ready);
        end
        cycle_a();
    endtask

    task automatic test_round_robin();
        int sent[N];
        int sel;
        for (int i = 0; i < int'(N); i++) sent[i] = 0;
        b_valid = '1; b_last = '1; b_dready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            // Seven all-valid beats, then port 1 alone (pointer at 3), then all again.
            sel = (k < 7) ? k % 4 : ((k == 7) ? 1 : 2);
            b_valid = (k == 7) ? 4'b0010 : 4'b1111;
            for (int i = 0; i < int'(N); i++) b_data[i*DW +: DW] = {4'(i), 12'(sent[i])};
            @(posedge clk);
            #1;
            compared++;
            if (b_dvalid !== 1'b1 || b_dport !== PB'(sel) || b_ddata !== {4'(sel), 12'(sent[sel])}
                || b_dlast !== 1'b0 || b_locked !== 1'b0) begin
                mismatched++;
                $display("FAIL rr_beat %0d: got v%b p%0d d%h l%b k%b expected 1 %0d %h 0 0",
                         k, b_dvalid, b_dport, b_ddata, b_dlast, b_locked, sel, {4'(sel), 12'(sent[sel])});
            end
            sent[sel]++;
        end
        b_valid = '0;
        @(posedge clk);
        #1;
        compared++;
        if (b_dvalid !== 1'b0) begin
            mismatched++;
            $display("FAIL rr_drain: got %b expected 0", b_dvalid);
        end
    endtask

    task automatic test_three_ports();
        int sel;
        c_valid = '1; c_last = '1; c_dready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sel = k % 3;
            for (int i = 0; i < int'(N3); i++) c_data[i*DW +: DW] = {4'(i), 12'(k / 3)};
            @(posedge clk);
            #1;
            compared++;
            if (c_dvalid !== 1'b1 || c_dport !== PB'(sel) || c_ddata !== {4'(sel), 12'(k / 3)}) begin
                mismatched++;
                $display("FAIL p3_beat %0d: got v%b p%0d d%h expected 1 %0d %h",
                         k, c_dvalid, c_dport, c_ddata, sel, {4'(sel), 12'(k / 3)});
            end
        end
        c_valid = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_packet_lock();
        int          exp_port[4] = '{2, 2, 2, 0};
        logic [3:0]  exp_lock    = 4'b0011;
        logic [3:0]  exp_last    = 4'b1100;
        logic [3:0]  valids[4]   = '{4'b0100, 4'b0101, 4'b0101, 4'b0001};
        logic [3:0]  lasts[4]    = '{4'b0000, 4'b0001, 4'b0101, 4'b0001};
        a_dready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_valid = valids[k];
            a_last  = lasts[k];
            cycle_a();
            compared++;
            if (a_dport !== PB'(exp_port[k]) || a_locked !== exp_lock[k] || a_dlast !== exp_last[k]) begin
                mismatched++;
                $display("FAIL pkt_beat %0d: got p%0d k%b l%b expected %0d %b %b",
                         k, a_dport, a_locked, a_dlast, exp_port[k], exp_lock[k], exp_last[k]);
            end
        end
        a_valid = '0;
        cycle_a();
    endtask

    task automatic test_backpressure();
        logic [15:0] hold_data;
        int          hold_port;
        bit          hold_last;
        a_valid = '1; a_last = '1; a_dready = 1'b1;
        cycle_a();
        hold_data = m_dd; hold_port = m_dp; hold_last = m_dl;
        a_dready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle_a();
            compared++;
            if (a_dvalid !== 1'b1 || a_ddata !== hold_data || a_dport !== PB'(hold_port)
                || a_dlast !== hold_last || a_ready !== 4'b0000) begin
                mismatched++;
                $display("FAIL stall %0d: got v%b d%h p%0d l%b r%b expected 1 %h %0d %b 0000",
                         k, a_dvalid, a_ddata, a_dport, a_dlast, a_ready, hold_data, hold_port, hold_last);
            end
        end
        a_dready = 1'b1;
        repeat (8) cycle_a();
    endtask

    task automatic test_wrap_sparse();
        a_dready = 1'b1; a_last = '1;
        a_valid = 4'b0100;
        cycle_a();
        a_valid = 4'b0010;
        cycle_a();
        compared++;
        if (a_dport !== 2'd1) begin
            mismatched++;
            $display("FAIL sparse_sel: got %0d expected 1", a_dport);
        end
        a_valid = 4'b1111;
        cycle_a();
        compared++;
        if (a_dport !== 2'd2) begin
            mismatched++;
            $display("FAIL sparse_next_ptr: got %0d expected 2", a_dport);
        end
        a_valid = '0;
        cycle_a();
    endtask

    task automatic test_locked_idle();
        a_dready = 1'b1;
        a_valid = 4'b0010; a_last = 4'b0000;
        cycle_a();
        compared++;
        if (a_dport !== 2'd1 || a_locked !== 1'b1) begin
            mismatched++;
            $display("FAIL idle_lock_start: got p%0d k%b expected 1 1", a_dport, a_locked);
        end
        a_valid = 4'b1000; a_last = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            cycle_a();
            compared++;
            if (a_dvalid !== 1'b0 || a_locked !== 1'b1 || a_ready !== 4'b0010) begin
                mismatched++;
                $display("FAIL idle_hold %0d: got v%b k%b r%b expected 0 1 0010",
                         k, a_dvalid, a_locked, a_ready);
            end
        end
        a_valid = 4'b1010; a_last = 4'b1010;
        cycle_a();
        compared++;
        if (a_dport !== 2'd1 || a_locked !== 1'b0 || a_dlast !== 1'b1) begin
            mismatched++;
            $display("FAIL idle_release: got p%0d k%b l%b expected 1 0 1", a_dport, a_locked, a_dlast);
        end
        a_valid = 4'b1000;
        cycle_a();
        compared++;
        if (a_dport !== 2'd3) begin
            mismatched++;
            $display("FAIL idle_other_port: got %0d expected 3", a_dport);
        end
        a_valid = '0;
        cycle_a();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            a_valid  = 4'($urandom);
            a_last   = 4'($urandom);
            a_dready = ($urandom_range(3) != 0);
            cycle_a();
        end
        // Finish any open packets so the lock releases, then drain.
        a_valid = '1; a_last = '1; a_dready = 1'b1;
        cycle_a();
        a_valid = '0;
        repeat (3) cycle_a();
        for (int i = 0; i < int'(N); i++) begin
            compared++;
            if (sink_seq[i] !== src_seq[i]) begin
                mismatched++;
                $display("FAIL scoreboard port %0d: received %0d expected %0d", i, sink_seq[i], src_seq[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_three_ports();
        test_packet_lock();
        test_backpressure();
        test_wrap_sparse();
        test_locked_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
